nibble_add_seq: RTL and testbench
=================================

Name: nibble_add_seq

Overview:
- Sequencer that computes a WIDTH-bit sum by time-multiplexing one external 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first.
- Sits between a requester (valid/ready operand interface) and the shared 4-bit adder datapath.
- Owns the operand registers, the inter-nibble carry register, the nibble index counter and the result register.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4; NIB = WIDTH/4.
- IDXW, derived, index counter width: clog2(NIB), minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  requester presents operands.
- in_ready  output  1  high only in IDLE; a transfer occurs when in_valid & in_ready.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- op_cin  input  1  carry-in to nibble 0.
- add_a  output  4  nibble of A driven to the adder slice.
- add_b  output  4  nibble of B driven to the adder slice.
- add_cin  output  1  carry driven to the adder slice.
- add_sum  input  4  adder slice sum, combinational from add_a/add_b/add_cin.
- add_cout  input  1  adder slice carry-out.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- result  output  WIDTH  final sum.
- res_cout  output  1  carry-out of the most significant nibble.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset, asynchronous:
  - state=IDLE; idx, carry, operand regs, result and res_cout all 0.
  - in_ready=1, res_valid=0, busy=0, add_a/add_b/add_cin=0.
  - Reset mid-RUN or mid-DONE aborts the operation; no partial result is ever flagged valid.
- States IDLE, RUN, DONE:
  - IDLE: in_ready=1. On in_valid, capture op_a, op_b and op_cin (into carry), clear idx and result, then go to RUN. in_valid low: stay.
  - RUN, one cycle per nibble:
    - Drive add_a=A[4*idx+3:4*idx], add_b=B[same], add_cin=carry.
    - At the clock edge, write add_sum into result[4*idx+3:4*idx], load carry<=add_cout, idx<=idx+1.
    - When idx==NIB-1, also load res_cout<=add_cout and go to DONE.
  - DONE: res_valid=1, and result/res_cout are held stable. When res_ready, go to IDLE (res_valid drops the next cycle). res_ready low: hold indefinitely.
- Adder slice outputs outside RUN: add_a=0, add_b=0, add_cin=0, so the shared slice sees idle inputs.
- Latency:
  - Handshake accepted at edge 0.
  - RUN occupies edges 1..NIB.
  - res_valid is high in the cycle after edge NIB.
  - Throughput: one operation per NIB+2 cycles minimum.
- Requester interface:
  - in_valid while busy is ignored; operands are not sampled outside IDLE.
  - op_a/op_b changing during RUN has no effect.
- Consumer interface: res_ready while not in DONE is ignored.
- Width rule: all nibble arithmetic is done by the slice. The block performs no addition itself except idx increment; idx never exceeds NIB-1.
- Edge case: WIDTH=4 gives a single RUN cycle.

Optional Feature:
- NIBBLE_ADD_SEQ_SUB_EN defined:
  - Adds input port op_sub (1 bit), sampled with the operands at the handshake.
  - op_sub=1: B is captured as ~op_b and carry is forced to 1 (op_cin ignored). The result is A-B, and res_cout=1 means no borrow.
  - op_sub=0: behaves as plain add.
- Undefined: no op_sub port, add-only. Timing is identical in both builds.

Test Plan (WIDTH=16):
- A=0x1234, B=0x4321, cin=0 -> result=0x5555, res_cout=0. res_valid rises exactly 5 cycles after the accepting edge; add_a sequence is 4,3,2,1.
- A=0xFFFF, B=0x0001, cin=0 -> result=0x0000, res_cout=1. add_cin sequence is 0,1,1,1, showing carry propagating across all nibbles.
- A=0xFFFF, B=0x0000, cin=1 -> result=0x0000, res_cout=1. A second back-to-back request A=0x0001, B=0x0001 -> 0x0002, accepted only after DONE->IDLE.
- Backpressure: res_ready held low 3 cycles in DONE while in_valid=1 with new operands -> result stays 0x5555, in_ready=0, and the new operands are not captured until IDLE.
- rst pulsed after 2 RUN cycles -> all outputs return to reset values immediately; in_ready=1 after release; the next request completes correctly.
- With NIBBLE_ADD_SEQ_SUB_EN: 0x0005-0x0007 -> result=0xFFFE, res_cout=0. 0x0007-0x0005 -> result=0x0002, res_cout=1.

Source files
------------

// File: rtl/nibble_add_seq_if.sv
// nibble_add_seq_if -- bundle of requester, adder-slice and consumer signals
// for the nibble-serial adder sequencer.
//
// Parameter: WIDTH  operand/result width in bits (multiple of 4, >= 4).
// Optional:  NIBBLE_ADD_SEQ_SUB_EN adds op_sub (subtract request).
//
// Signals:
//   in_valid/in_ready, op_a, op_b, op_cin  operand handshake
//   add_a, add_b, add_cin                  drive to the shared 4-bit slice
//   add_sum, add_cout                      combinational slice response
//   res_valid/res_ready, result, res_cout  result handshake
//   busy                                   operation in flight
//
// Modports: slave  = sequencer side
//           master = requester / consumer / slice side
interface nibble_add_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_cin;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
   logic             op_sub;
`endif
   logic [3:0]       add_a;
   logic [3:0]       add_b;
   logic             add_cin;
   logic [3:0]       add_sum;
   logic             add_cout;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] result;
   logic             res_cout;
   logic             busy;

   modport slave (
`ifdef NIBBLE_ADD_SEQ_SUB_EN
      input  op_sub,
`endif
      input  in_valid, op_a, op_b, op_cin, add_sum, add_cout, res_ready,
      output in_ready, add_a, add_b, add_cin, res_valid, result, res_cout, busy
   );

   modport master (
`ifdef NIBBLE_ADD_SEQ_SUB_EN
      output op_sub,
`endif
      output in_valid, op_a, op_b, op_cin, add_sum, add_cout, res_ready,
      input  in_ready, add_a, add_b, add_cin, res_valid, result, res_cout, busy
   );
endinterface

// File: rtl/nibble_add_seq.sv
// nibble_add_seq -- computes a WIDTH-bit sum by sending one nibble per clock
// through an external 4-bit ripple-carry slice, LSB nibble first.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   nibble_add_seq_if.slave (operand handshake, slice drive/response,
//         result handshake, busy)
//
// Parameter: WIDTH (multiple of 4, >= 4), default 16.
// Optional:  NIBBLE_ADD_SEQ_SUB_EN -- op_sub=1 captures ~op_b with carry
//            forced to 1, giving A-B (res_cout=1 means no borrow).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | in_ready=1, waiting for operands
// RUN   | one nibble per cycle through the slice, idx = current nibble
// DONE  | res_valid=1, result held until res_ready
module nibble_add_seq #(
   parameter int WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   nibble_add_seq_if.slave        bus
);
   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

   if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
      $error("nibble_add_seq: WIDTH must be a multiple of 4 and at least 4");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             res_cout_q, res_cout_d;

   logic             last_nib;

   assign last_nib = (idx_q == IDX_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         result_q   <= '0;
         res_cout_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         carry_q    <= carry_d;
         a_q        <= a_d;
         b_q        <= b_d;
         result_q   <= result_d;
         res_cout_q <= res_cout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.in_valid)  state_d = S_RUN;
         S_RUN:   if (last_nib)      state_d = S_DONE;
         S_DONE:  if (bus.res_ready) state_d = S_IDLE;
         default:                    state_d = S_IDLE;
      endcase
   end

   // Datapath next-state: operand capture in IDLE, nibble write-back in RUN.
   always_comb begin
      idx_d      = idx_q;
      carry_d    = carry_q;
      a_d        = a_q;
      b_d        = b_q;
      result_d   = result_q;
      res_cout_d = res_cout_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d        = bus.op_a;
               idx_d      = '0;
               result_d   = '0;
               res_cout_d = 1'b0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
               b_d        = bus.op_sub ? ~bus.op_b : bus.op_b;
               carry_d    = bus.op_sub ? 1'b1 : bus.op_cin;
`else
               b_d        = bus.op_b;
               carry_d    = bus.op_cin;
`endif
            end
         end
         S_RUN: begin
            result_d[4*int'(idx_q) +: 4] = bus.add_sum;
            carry_d = bus.add_cout;
            if (last_nib) begin
               // Park idx at 0 rather than stepping past the last nibble.
               idx_d      = '0;
               res_cout_d = bus.add_cout;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == S_IDLE);
      bus.busy      = (state_q != S_IDLE);
      bus.res_valid = (state_q == S_DONE);
      bus.result    = result_q;
      bus.res_cout  = res_cout_q;
      bus.add_a     = 4'd0;
      bus.add_b     = 4'd0;
      bus.add_cin   = 1'b0;
      if (state_q == S_RUN) begin
         bus.add_a   = a_q[4*int'(idx_q) +: 4];
         bus.add_b   = b_q[4*int'(idx_q) +: 4];
         bus.add_cin = carry_q;
      end
   end
endmodule

// File: tb/tb_nibble_add_seq.sv
module tb_nibble_add_seq;
   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   nibble_add_seq_if #(.WIDTH(WIDTH)) bus ();

   nibble_add_seq #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // External 4-bit slice.
   assign {bus.add_cout, bus.add_sum} =
      {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'd0, bus.add_cin};

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   logic [WIDTH:0] sb[$];
   logic [3:0]     tr_a[$];
   logic           tr_cin[$];
   logic [WIDTH:0] mon_exp;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: plain WIDTH-bit arithmetic; bit WIDTH is the carry-out.
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic cin, input logic sub);
      logic [WIDTH-1:0] bb;
      logic             c;
      bb = sub ? ~b : b;
      c  = sub ? 1'b1 : cin;
      return {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(c);
   endfunction

   // Scoreboard monitor: compare on every result transfer.
   always @(negedge clk) begin
      if (!rst && bus.res_valid && bus.res_ready) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_result: got 0x%0h with no expected entry", bus.result);
         end else begin
            mon_exp = sb.pop_front();
            chk("result",   32'(bus.result),   32'(mon_exp[WIDTH-1:0]));
            chk("res_cout", 32'(bus.res_cout), 32'(mon_exp[WIDTH]));
         end
      end
   end

   // Slice drive trace while running.
   always @(negedge clk) begin
      if (!rst && bus.busy && !bus.res_valid) begin
         tr_a.push_back(bus.add_a);
         tr_cin.push_back(bus.add_cin);
      end
   end

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub, input bit push,
                       output int acc_cyc);
      bit ok;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.op_cin   = cin;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
      bus.op_sub   = sub;
`endif
      bus.in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_total++;
         $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 40 cycles");
      end
      tr_a.delete();
      tr_cin.delete();
      acc_cyc = cyc;
      if (push) sb.push_back(model(a, b, cin, sub));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.op_a     = WIDTH'($urandom);
      bus.op_b     = WIDTH'($urandom);
      bus.op_cin   = 1'($urandom);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n++;
         if (bus.res_valid) return;
      end
      n_total++;
      $display("FAIL done_timeout: res_valid stayed 0, expected 1 within 40 cycles");
   endtask

   int n, acc1, acc2;
   logic [15:0] pk;
   logic [3:0]  pc;
   logic [WIDTH-1:0] ra, rb;
   logic rc, rs;

   initial begin
      bus.in_valid  = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.op_cin    = 1'b0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
      bus.op_sub    = 1'b0;
`endif
      bus.res_ready = 1'b1;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_result",    32'(bus.result),    32'd0);
      chk("rst_add_a",     32'(bus.add_a),     32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic add, latency, nibble order
      send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, acc1);
      wait_done(n);
      chk("latency", 32'(n), 32'd5);
      chk("add_a_seq_len", 32'(tr_a.size()), 32'(NIB));
      if (tr_a.size() == 4) begin
         pk = {tr_a[0], tr_a[1], tr_a[2], tr_a[3]};
         chk("add_a_seq", 32'(pk), 32'h4321);
      end

      // Full carry ripple
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc1);
      wait_done(n);
      chk("add_cin_seq_len", 32'(tr_cin.size()), 32'(NIB));
      if (tr_cin.size() == 4) begin
         pc = {tr_cin[0], tr_cin[1], tr_cin[2], tr_cin[3]};
         chk("add_cin_seq", 32'(pc), 32'b0111);
      end

      // Back-to-back
      send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, acc1);
      send(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, acc2);
      chk("b2b_spacing", 32'(acc2 - acc1), 32'(NIB + 2));
      wait_done(n);

      // Backpressure in DONE with a new request pending
      send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, acc1);
      bus.res_ready = 1'b0;
      wait_done(n);
      bus.op_a     = 16'h0F0F;
      bus.op_b     = 16'h0101;
      bus.op_cin   = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         chk("bp_result",    32'(bus.result),    32'h5555);
         chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
         chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
      end
      @(posedge clk); #1;
      bus.res_ready = 1'b1;
      send(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b1, acc1);
      wait_done(n);

      // Reset after two RUN cycles
      send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, acc1);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("mid_rst_busy",      32'(bus.busy),      32'd0);
      chk("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("mid_rst_result",    32'(bus.result),    32'd0);
      chk("mid_rst_res_cout",  32'(bus.res_cout),  32'd0);
      chk("mid_rst_add",       32'({bus.add_a, bus.add_b, bus.add_cin}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      send(16'hABCD, 16'h1234, 1'b1, 1'b0, 1'b1, acc1);
      wait_done(n);

`ifdef NIBBLE_ADD_SEQ_SUB_EN
      send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, acc1);
      wait_done(n);
      send(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1, acc1);
      wait_done(n);
`endif

      // Random back-to-back traffic
      for (int k = 0; k < 25; k++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         rc = 1'($urandom);
`ifdef NIBBLE_ADD_SEQ_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         send(ra, rb, rc, rs, 1'b1, acc1);
      end
      wait_done(n);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
